// File: rtl/writeback_stage.sv
// Y86-64 writeback stage: M/W pipeline register, 15-entry register file,
// and sticky halt tracking.
//
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   M_stat, mem_error     incoming status; mem_error forces ADR
//   M_icode, M_valE,      memory-stage results latched into W
//   m_valM, M_dstE,
//   M_dstM
//   W_stall               holds the W register
//   srcA/srcB, d_rvalA/B  combinational decode read ports
//   W_*                   latched W register (also forwarding sources)
//   halted                sticky: a non-AOK status has retired
`default_nettype none

module writeback_stage #(
   parameter int WIDTH = 64,
   parameter int NREGS = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [2:0]       M_stat,
   input  logic             mem_error,
   input  logic [3:0]       M_icode,
   input  logic [WIDTH-1:0] M_valE,
   input  logic [WIDTH-1:0] m_valM,
   input  logic [3:0]       M_dstE,
   input  logic [3:0]       M_dstM,
   input  logic             W_stall,
   input  logic [3:0]       srcA,
   input  logic [3:0]       srcB,
   output logic [WIDTH-1:0] d_rvalA,
   output logic [WIDTH-1:0] d_rvalB,
   output logic [2:0]       W_stat,
   output logic [3:0]       W_icode,
   output logic [WIDTH-1:0] W_valE,
   output logic [WIDTH-1:0] W_valM,
   output logic [3:0]       W_dstE,
   output logic [3:0]       W_dstM,
   output logic             halted
);

   localparam logic [3:0] RNONE = 4'hF;
   localparam logic [3:0] I_NOP = 4'h1;
   localparam logic [2:0] S_AOK = 3'd1;
   localparam logic [2:0] S_ADR = 3'd3;

   logic [2:0]       m_stat;
   logic             commit;
   logic             w_load;
   logic [WIDTH-1:0] rf [NREGS];

   assign m_stat = mem_error ? S_ADR : M_stat;
   assign w_load = !W_stall && !halted;
   // Only an AOK instruction that retires before the halt may commit.
   assign commit = !halted && (W_stat == S_AOK);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         W_stat  <= S_AOK;
         W_icode <= I_NOP;
         W_valE  <= '0;
         W_valM  <= '0;
         W_dstE  <= RNONE;
         W_dstM  <= RNONE;
      end else if (w_load) begin
         W_stat  <= m_stat;
         W_icode <= M_icode;
         W_valE  <= M_valE;
         W_valM  <= m_valM;
         W_dstE  <= M_dstE;
         W_dstM  <= M_dstM;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         halted <= 1'b0;
      end else if (!halted && (W_stat != S_AOK)) begin
         halted <= 1'b1;
      end
   end

   // M port is written last so it wins when dstE == dstM (popq %rsp).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            rf[i] <= '0;
         end
      end else if (commit) begin
         if (W_dstE != RNONE) begin
            rf[W_dstE] <= W_valE;
         end
         if (W_dstM != RNONE) begin
            rf[W_dstM] <= W_valM;
         end
      end
   end

   assign d_rvalA = (srcA == RNONE) ? '0 : rf[srcA];
   assign d_rvalB = (srcB == RNONE) ? '0 : rf[srcB];

endmodule

`default_nettype wire

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage with a reference model
// of the W register, register file and halt flag.
module tb_writeback_stage;

   typedef struct packed {
      logic [2:0]  stat;
      logic [3:0]  icode;
      logic [63:0] valE;
      logic [63:0] valM;
      logic [3:0]  dstE;
      logic [3:0]  dstM;
   } wreg_t;

   logic        clk;
   logic        rst_n;
   logic [2:0]  M_stat;
   logic        mem_error;
   logic [3:0]  M_icode;
   logic [63:0] M_valE;
   logic [63:0] m_valM;
   logic [3:0]  M_dstE;
   logic [3:0]  M_dstM;
   logic        W_stall;
   logic [3:0]  srcA;
   logic [3:0]  srcB;
   logic [63:0] d_rvalA;
   logic [63:0] d_rvalB;
   logic [2:0]  W_stat;
   logic [3:0]  W_icode;
   logic [63:0] W_valE;
   logic [63:0] W_valM;
   logic [3:0]  W_dstE;
   logic [3:0]  W_dstM;
   logic        halted;

   int checks = 0;
   int errors = 0;

   logic [63:0] mreg [15];
   wreg_t       mw;
   logic        mh;

   wreg_t bubble;
   wreg_t wout;

   writeback_stage #(.WIDTH(64), .NREGS(15)) dut (
      .clk(clk), .rst_n(rst_n),
      .M_stat(M_stat), .mem_error(mem_error),
      .M_icode(M_icode), .M_valE(M_valE), .m_valM(m_valM),
      .M_dstE(M_dstE), .M_dstM(M_dstM), .W_stall(W_stall),
      .srcA(srcA), .srcB(srcB),
      .d_rvalA(d_rvalA), .d_rvalB(d_rvalB),
      .W_stat(W_stat), .W_icode(W_icode),
      .W_valE(W_valE), .W_valM(W_valM),
      .W_dstE(W_dstE), .W_dstM(W_dstM),
      .halted(halted)
   );

   assign wout = {W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void model_reset();
      for (int i = 0; i < 15; i++) mreg[i] = 64'h0;
      mw = bubble;
      mh = 1'b0;
   endfunction

   // Architectural effect of one clock edge, from pre-edge values.
   function automatic void model_step();
      wreg_t old = mw;
      logic  oh = mh;
      if (!oh && old.stat == 3'd1) begin
         if (old.dstE != 4'hF) mreg[old.dstE] = old.valE;
         if (old.dstM != 4'hF) mreg[old.dstM] = old.valM;
      end
      if (!oh && old.stat != 3'd1) mh = 1'b1;
      if (!W_stall && !oh)
         mw = '{stat: (mem_error ? 3'd3 : M_stat), icode: M_icode,
                valE: M_valE, valM: m_valM, dstE: M_dstE, dstM: M_dstM};
   endfunction

   function automatic logic [63:0] exp_rd(logic [3:0] s);
      if (s == 4'hF) return 64'h0;
      return mreg[s];
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic drive(logic [3:0] ic, logic [63:0] ve, logic [63:0] vm,
                        logic [3:0] de, logic [3:0] dm);
      M_stat = 3'd1; mem_error = 1'b0;
      M_icode = ic; M_valE = ve; m_valM = vm;
      M_dstE = de; M_dstM = dm;
   endtask

   task automatic drive_rand();
      M_icode = 4'($urandom);
      M_valE = {$urandom, $urandom};
      m_valM = {$urandom, $urandom};
      M_dstE = 4'($urandom_range(0, 15));
      M_dstM = 4'($urandom_range(0, 15));
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      W_stall = 1'b0;
      drive(4'h1, 64'h0, 64'h0, 4'hF, 4'hF);
      srcA = 4'hF; srcB = 4'hF;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (wout !== bubble) begin
         errors++;
         $display("FAIL reset_w got %h want %h", wout, bubble);
      end
      checks++;
      if (halted !== 1'b0) begin
         errors++;
         $display("FAIL reset_halted got %b want 0", halted);
      end
      for (int i = 0; i < 16; i++) begin
         srcA = 4'(i);
         #1;
         checks++;
         if (d_rvalA !== 64'h0) begin
            errors++;
            $display("FAIL reset_rd r%0d got %h want 0", i, d_rvalA);
         end
      end
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_irmovq();
      drive(4'h3, 64'h10, 64'h0, 4'd2, 4'hF);
      tick();
      checks++;
      if (W_valE !== 64'h10 || W_dstE !== 4'd2) begin
         errors++;
         $display("FAIL irmovq_w got %h/%h want 10/2", W_valE, W_dstE);
      end
      srcA = 4'd2;
      tick();
      checks++;
      if (d_rvalA !== 64'h10) begin
         errors++;
         $display("FAIL irmovq_rd got %h want 10", d_rvalA);
      end
   endtask

   task automatic test_popq_rsp();
      drive(4'hB, 64'h108, 64'hDEAD, 4'd4, 4'd4);
      tick();
      tick();
      srcA = 4'd4;
      #1;
      checks++;
      if (d_rvalA !== 64'hDEAD) begin
         errors++;
         $display("FAIL popq_rsp got %h want dead", d_rvalA);
      end
   endtask

   task automatic test_same_cycle_read();
      drive(4'h3, 64'h55, 64'h0, 4'd3, 4'hF);
      tick();
      drive(4'h1, 64'h0, 64'h0, 4'hF, 4'hF);
      srcB = 4'd3;
      #1;
      checks++;
      if (d_rvalB !== 64'h0) begin
         errors++;
         $display("FAIL same_cycle_old got %h want 0", d_rvalB);
      end
      tick();
      checks++;
      if (d_rvalB !== 64'h55) begin
         errors++;
         $display("FAIL same_cycle_new got %h want 55", d_rvalB);
      end
   endtask

   task automatic test_stall();
      wreg_t held = mw;
      W_stall = 1'b1;
      for (int c = 0; c < 3; c++) begin
         drive_rand();
         tick();
         checks++;
         if (wout !== held) begin
            errors++;
            $display("FAIL stall_hold c%0d got %h want %h", c, wout, held);
         end
      end
      W_stall = 1'b0;
      drive(4'h6, 64'h1234, 64'h5678, 4'd7, 4'd8);
      tick();
      checks++;
      if (wout !== {3'd1, 4'h6, 64'h1234, 64'h5678, 4'd7, 4'd8}) begin
         errors++;
         $display("FAIL stall_release got %h", wout);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 200; c++) begin
         drive_rand();
         W_stall = ($urandom_range(0, 3) == 0);
         srcA = 4'($urandom_range(0, 15));
         srcB = 4'($urandom_range(0, 15));
         #1;
         checks++;
         if (d_rvalA !== exp_rd(srcA) || d_rvalB !== exp_rd(srcB)) begin
            errors++;
            $display("FAIL rand_rd c%0d got %h/%h want %h/%h", c,
                     d_rvalA, d_rvalB, exp_rd(srcA), exp_rd(srcB));
         end
         tick();
         checks++;
         if (wout !== mw || halted !== mh) begin
            errors++;
            $display("FAIL rand_w c%0d got %h h%b want %h h%b", c,
                     wout, halted, mw, mh);
         end
      end
      W_stall = 1'b0;
   endtask

   task automatic test_mem_error();
      logic [63:0] r5;
      wreg_t       frozen;
      r5 = mreg[5];
      drive(4'h5, 64'hBAD0, 64'hBAD1, 4'd5, 4'hF);
      mem_error = 1'b1;
      tick();
      checks++;
      if (W_stat !== 3'd3 || halted !== 1'b0) begin
         errors++;
         $display("FAIL mem_err_stat got %0d h%b want 3 h0", W_stat, halted);
      end
      drive(4'h3, 64'h77, 64'h0, 4'd5, 4'hF);
      tick();
      checks++;
      if (halted !== 1'b1) begin
         errors++;
         $display("FAIL mem_err_halt got %b want 1", halted);
      end
      frozen = mw;
      for (int c = 0; c < 3; c++) begin
         drive_rand();
         W_stall = 1'($urandom);
         tick();
         checks++;
         if (wout !== frozen || halted !== 1'b1) begin
            errors++;
            $display("FAIL mem_err_frozen c%0d got %h want %h", c, wout, frozen);
         end
      end
      W_stall = 1'b0;
      srcA = 4'd5;
      #1;
      checks++;
      if (d_rvalA !== r5) begin
         errors++;
         $display("FAIL mem_err_r5 got %h want %h", d_rvalA, r5);
      end
      for (int i = 0; i < 15; i++) begin
         srcB = 4'(i);
         #1;
         checks++;
         if (d_rvalB !== mreg[i]) begin
            errors++;
            $display("FAIL halt_rf r%0d got %h want %h", i, d_rvalB, mreg[i]);
         end
      end
   endtask

   task automatic test_reset_midop();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      model_reset();
      checks++;
      if (halted !== 1'b0 || wout !== bubble) begin
         errors++;
         $display("FAIL async_rst got %h h%b want %h h0", wout, halted, bubble);
      end
      for (int i = 0; i < 15; i++) begin
         srcA = 4'(i);
         #0.1;
         checks++;
         if (d_rvalA !== 64'h0) begin
            errors++;
            $display("FAIL async_rst_rd r%0d got %h want 0", i, d_rvalA);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      bubble = {3'd1, 4'h1, 64'h0, 64'h0, 4'hF, 4'hF};
      test_reset();
      test_irmovq();
      test_popq_rsp();
      test_same_cycle_read();
      test_stall();
      test_random();
      test_mem_error();
      test_reset_midop();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
